food_place_ctrl: RTL



---
 rtl/food_place_ctrl_pkg.sv | 23 ++
 rtl/food_place_ctrl_if.sv | 15 +
 rtl/food_sample_timer.sv | 38 +++
 rtl/food_place_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/food_place_ctrl_pkg.sv
// Shared types and grid constants for the food placement controller.
// The grid defaults are also consumed by the render and snake-body blocks.
package food_place_ctrl_pkg;

    localparam int COORD_W    = 7;
    localparam int GRID_X_DEF = 40;
    localparam int GRID_Y_DEF = 30;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP_X,
        S_GAP_Y,
        S_RANGE,
        S_QUERY,
        S_DONE,
        S_SCAN,
        S_FAIL
    } state_t;

endpackage

// File: rtl/food_place_ctrl_if.sv
// Occupancy query handshake between the food placer (master) and the
// snake-body lookup (slave).
interface food_place_ctrl_if;
    import food_place_ctrl_pkg::*;

    logic   occ_req;
    coord_t occ_x;
    coord_t occ_y;
    logic   occ_ack;
    logic   occ_hit;

    modport master (output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
    modport slave  (input occ_req, occ_x, occ_y, output occ_ack, occ_hit);

endinterface

// File: rtl/food_sample_timer.sv
// Gap counter that spaces PRBS samples SAMPLE_GAP cycles apart and raises
// the X or Y capture strobe when the gap expires.
module food_sample_timer #(
    parameter int SAMPLE_GAP = 7
) (
    input  logic clock_25,
    input  logic reset,
    input  logic load,
    input  logic run,
    input  logic want_x,
    input  logic want_y,
    output logic cap_x,
    output logic cap_y
);

    localparam int            CW     = (SAMPLE_GAP < 2) ? 1 : $clog2(SAMPLE_GAP + 1);
    localparam logic [CW-1:0] GAP_LD = CW'(SAMPLE_GAP);

    logic [CW-1:0] gap_cnt;
    logic          tick;

    assign tick  = run && (gap_cnt == CW'(1));
    assign cap_x = tick && want_x;
    assign cap_y = tick && want_y;

    // The counter keeps running through the range check so a rejected pair
    // still yields samples exactly SAMPLE_GAP cycles apart.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            gap_cnt <= GAP_LD;
        end else if (load || tick) begin
            gap_cnt <= GAP_LD;
        end else if (run) begin
            gap_cnt <= gap_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/food_place_ctrl.sv
// Food placement controller: samples PRBS X/Y candidates, range-checks them and
// queries body occupancy until a free cell is found. FOOD_SCAN_FALLBACK_EN adds a row-major scan after MAX_TRIES.
module food_place_ctrl
    import food_place_ctrl_pkg::*;
#(
    parameter int GRID_X     = GRID_X_DEF,
    parameter int GRID_Y     = GRID_Y_DEF,
    parameter int SAMPLE_GAP = 7,
    parameter int MAX_TRIES  = 16
) (
    input  logic                     clock_25,
    input  logic                     reset,
    input  logic                     place_req,
    input  coord_t                   rnd,
    food_place_ctrl_if.master        occ,
    output coord_t                   food_x,
    output coord_t                   food_y,
    output logic                     food_valid,
    output logic                     place_done,
    output logic                     busy,
    output logic                     fail
);

    localparam int         TW    = $clog2(MAX_TRIES + 1);
    localparam coord_ext_t LIM_X = coord_ext_t'(GRID_X);
    localparam coord_ext_t LIM_Y = coord_ext_t'(GRID_Y);

    state_t        state;
    state_t        state_nx;
    logic          load;
    logic          run;
    logic          want_x;
    logic          want_y;
    logic          cap_x;
    logic          cap_y;
    logic          try_inc;
    coord_t        cand_x;
    coord_t        cand_y;
    logic [TW-1:0] try_cnt;
    logic          in_range;
    logic          last_try;
    logic          accept;
    logic          range_pass;
    logic          query_free;

`ifdef FOOD_SCAN_FALLBACK_EN
    localparam state_t EXHAUST_ST = S_SCAN;
    localparam coord_t LAST_X     = coord_t'(GRID_X - 1);
    localparam coord_t LAST_Y     = coord_t'(GRID_Y - 1);
    logic scan_mode;
    logic scan_last;
    assign scan_last = (occ.occ_x == LAST_X) && (occ.occ_y == LAST_Y);
`else
    localparam state_t EXHAUST_ST = S_FAIL;
`endif

    // Unsigned compare with no modulo folding keeps the distribution unbiased.
    assign in_range   = ({1'b0, cand_x} < LIM_X) && ({1'b0, cand_y} < LIM_Y);
    assign last_try   = (try_cnt + TW'(1)) == TW'(MAX_TRIES);
    assign run        = (state == S_GAP_X) || (state == S_GAP_Y) || (state == S_RANGE);
    assign want_x     = (state == S_GAP_X);
    assign want_y     = (state == S_GAP_Y);
    assign accept     = (state == S_IDLE) && place_req;
    assign range_pass = (state == S_RANGE) && in_range;
    assign query_free = (state == S_QUERY) && occ.occ_ack && !occ.occ_hit;

    assign occ.occ_req = (state == S_QUERY);
    assign place_done  = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    food_sample_timer #(
        .SAMPLE_GAP (SAMPLE_GAP)
    ) u_timer (
        .clock_25 (clock_25),
        .reset    (reset),
        .load     (load),
        .run      (run),
        .want_x   (want_x),
        .want_y   (want_y),
        .cap_x    (cap_x),
        .cap_y    (cap_y)
    );

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        try_inc  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (place_req) begin
                    state_nx = S_GAP_X;
                    load     = 1'b1;
                end
            end
            S_GAP_X: if (cap_x) state_nx = S_GAP_Y;
            S_GAP_Y: if (cap_y) state_nx = S_RANGE;
            S_RANGE: begin
                if (in_range) begin
                    state_nx = S_QUERY;
                end else begin
                    try_inc  = 1'b1;
                    state_nx = last_try ? EXHAUST_ST : S_GAP_X;
                end
            end
            S_QUERY: begin
                if (occ.occ_ack) begin
                    if (!occ.occ_hit) begin
                        state_nx = S_DONE;
`ifdef FOOD_SCAN_FALLBACK_EN
                    end else if (scan_mode) begin
                        state_nx = scan_last ? S_FAIL : S_SCAN;
`endif
                    end else begin
                        try_inc  = 1'b1;
                        load     = 1'b1;
                        state_nx = last_try ? EXHAUST_ST : S_GAP_X;
                    end
                end
            end
            S_DONE: state_nx = S_IDLE;
            S_FAIL: state_nx = S_IDLE;
`ifdef FOOD_SCAN_FALLBACK_EN
            S_SCAN: state_nx = S_QUERY;
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            cand_x     <= '0;
            cand_y     <= '0;
            try_cnt    <= '0;
            occ.occ_x  <= '0;
            occ.occ_y  <= '0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            fail       <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_mode  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                try_cnt    <= '0;
                food_valid <= 1'b0;
                fail       <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
                scan_mode  <= 1'b0;
`endif
            end
            if (cap_x) cand_x <= rnd;
            if (cap_y) cand_y <= rnd;
            if (try_inc) try_cnt <= try_cnt + TW'(1);
            if (range_pass) begin
                occ.occ_x <= cand_x;
                occ.occ_y <= cand_y;
            end
            if (query_free) begin
                food_x <= occ.occ_x;
                food_y <= occ.occ_y;
            end
            if (state == S_DONE) food_valid <= 1'b1;
            if (state == S_FAIL) fail <= 1'b1;
`ifdef FOOD_SCAN_FALLBACK_EN
            // First SCAN visit starts at (0,0); later visits step row-major.
            if (state == S_SCAN) begin
                if (!scan_mode) begin
                    scan_mode <= 1'b1;
                    occ.occ_x <= '0;
                    occ.occ_y <= '0;
                end else if (occ.occ_x == LAST_X) begin
                    occ.occ_x <= '0;
                    occ.occ_y <= occ.occ_y + coord_t'(1);
                end else begin
                    occ.occ_x <= occ.occ_x + coord_t'(1);
                end
            end
`endif
        end
    end

endmodule
